fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end that replaces the bare PC register and i_cache/fetch_decode_pipe coupling.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_unit_sync_fifo.sv | 85 ++++++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types, constants and width helpers for the
//                instruction-fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Every instruction occupies one 32-bit word.
  localparam int INSTR_BYTES = 4;

  // Widths of the default 32-bit configuration.
  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_DATA_WIDTH    = 32;

  // One prefetch buffer entry in the default configuration.
  typedef struct packed {
    logic [DEF_ADDRESS_WIDTH-1:0] pc;
    logic [DEF_DATA_WIDTH-1:0]    instr;
  } fetch_entry_t;

  // Bits needed for a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // Counter widths of the default configuration (MAX_OUTST=2, FIFO_DEPTH=4).
  localparam int DEF_OUTST_WIDTH = cnt_width(2);
  localparam int DEF_COUNT_WIDTH = cnt_width(4);

endpackage
`default_nettype wire

// File: rtl/fetch_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Circular-buffer FIFO with push/pop/flush. Push and pop may
//                coincide at any occupancy; flush has priority over both.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  // A pop frees the head slot in the same cycle, so a push is accepted when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy; flush empties the buffer.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once they have been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end. Issues in-order requests to a
//                variable-latency imem port, buffers responses in a prefetch
//                FIFO and hands {pc, instr, pc+4} to decode. Responses still
//                in flight at a redirect are counted and discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter int                         FIFO_DEPTH    = 4,
  parameter int                         MAX_OUTST     = 2,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [DATA_WIDTH-1:0]    dec_instr,
  output logic [ADDRESS_WIDTH-1:0] dec_pc,
  output logic [ADDRESS_WIDTH-1:0] dec_pc_plus4
);

  localparam int OUTST_W = cnt_width(MAX_OUTST);
  localparam int COUNT_W = cnt_width(FIFO_DEPTH);
  localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(INSTR_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(INSTR_BYTES - 1);

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [OUTST_W-1:0]       outst_q, outst_d;
  logic [OUTST_W-1:0]       drop_q, drop_d;
  logic                     init_q;

  logic                     gnt_fire;
  logic                     credit_ok;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [COUNT_W-1:0]       fifo_count;
  logic [ENTRY_W-1:0]       fifo_head;
  logic [ADDRESS_WIDTH-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & ~ALIGN_MASK;

  // Every live (non-dropped) request must have a guaranteed FIFO slot on return.
  assign credit_ok = (int'(fifo_count) + int'(outst_q) - int'(drop_q)) < FIFO_DEPTH;

  // init_q holds issue off for the first cycle after reset.
  assign imem_req  = !rst && !init_q && !redirect &&
                     (outst_q < OUTST_W'(MAX_OUTST)) && credit_ok;
  assign imem_addr = fetch_pc_q;
  assign gnt_fire  = imem_req && imem_gnt;

  // Stale responses (drop_q > 0) and responses in a redirect cycle never enter the FIFO.
  assign fifo_push = imem_rvalid && (drop_q == '0) && !redirect;
  assign dec_valid = !fifo_empty && !redirect && !rst;
  assign fifo_pop  = dec_valid && dec_ready;

  assign dec_pc       = fifo_head[ENTRY_W-1:DATA_WIDTH];
  assign dec_instr    = fifo_head[DATA_WIDTH-1:0];
  assign dec_pc_plus4 = dec_pc + PC_STEP;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({resp_pc_q, imem_rdata}),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state for the PC counters and in-flight bookkeeping; redirect overrides.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + OUTST_W'(gnt_fire) - OUTST_W'(imem_rvalid);
    if (gnt_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (fifo_push) begin
      resp_pc_d = resp_pc_q + PC_STEP;
    end
    if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - OUTST_W'(1);
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      // outst_q already includes the responses still pending discard, so
      // everything left in flight after this cycle's response is stale.
      drop_d     = outst_q - OUTST_W'(imem_rvalid);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      init_q     <= 1'b1;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      init_q     <= 1'b0;
    end
  end

  a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outst_q == '0)));

  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed vector table,
//                hand-written redirect/reset sequences and a randomized run
//                against an in-order memory model and a PC-stream reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          dec_valid;
  logic          dec_ready = 1'b0;
  logic [DW-1:0] dec_instr;
  logic [AW-1:0] dec_pc;
  logic [AW-1:0] dec_pc_plus4;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .MAX_OUTST     (MAXO),
    .RESET_PC      (RPC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .dec_pc_plus4 (dec_pc_plus4)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ndec     = 0;
  int lat_min  = 1;
  int lat_max  = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];              // granted requests awaiting their response, in order

  logic [31:0] exp_addr = RPC; // next address the fetcher must request
  logic [31:0] exp_dec  = RPC; // next PC decode must see
  logic        prev_rst = 1'b0;
  logic        s_req, s_dv;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: drive inputs and memory response at negedge, check the
  // outputs against the reference, then advance the reference for the edge.
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                      input logic g, input logic dr);
    logic rv;
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rpc; imem_gnt = g; dec_ready = dr;
    rv = 1'b0;
    if (r) pend.delete();
    else if (pend.size() > 0 && pend[0].due <= cyc) rv = 1'b1;
    imem_rvalid = rv;
    if (rv) begin
      imem_rdata = mem_f(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rdata = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_dv = dec_valid; s_pc = dec_pc;
    if (r || rd || prev_rst) chk("req_blocked", 32'(imem_req), 32'd0);
    if (r || prev_rst)       chk("dv_after_rst", 32'(dec_valid), 32'd0);
    if (rd)                  chk("dv_in_redirect", 32'(dec_valid), 32'd0);
    if (imem_req) begin
      chk("imem_addr", imem_addr, exp_addr);
      chk("outst_limit", 32'((pend.size() + int'(rv)) < MAXO), 32'd1);
    end
    if (dec_valid) begin
      chk("dec_pc", dec_pc, exp_dec);
      chk("dec_instr", dec_instr, mem_f(exp_dec));
      chk("dec_pc_plus4", dec_pc_plus4, exp_dec + 32'd4);
    end
    if (r) begin
      exp_addr = RPC; exp_dec = RPC;
    end else if (rd) begin
      exp_addr = rpc & ~32'h3; exp_dec = rpc & ~32'h3;
    end else begin
      if (imem_req && g) begin
        pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        exp_addr = exp_addr + 32'd4;
      end
      if (dec_valid && dr) begin
        exp_dec = exp_dec + 32'd4;
        ndec++;
      end
    end
    prev_rst = r;
    cyc++;
  endtask

  // Run up to max_cyc plain cycles until decode is valid; check the head PC.
  task automatic wait_dv(input string name, input logic [31:0] pc, input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_dv) begin
        found = 1'b1;
        chk(name, s_pc, pc);
      end
    end
    if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Run up to max_cyc plain cycles until a request is raised; check its address.
  task automatic wait_req(input string name, input logic [31:0] addr, input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_req) begin
        found = 1'b1;
        chk(name, s_addr, addr);
      end
    end
    if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, rd, g, dr;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vt[$];

  task automatic addv(input logic r, input logic dr, input logic e_req,
                      input logic [31:0] e_addr, input logic e_dv, input logic [31:0] e_pc);
    vt.push_back('{r: r, rd: 1'b0, g: 1'b1, dr: dr, rpc: 32'h0,
                   e_req: e_req, e_addr: e_addr, e_dv: e_dv, e_pc: e_pc});
  endtask

  initial begin : main
    logic found;

    // Streaming, latency 1, decode always ready.
    addv(1, 1, 0, 0,     0, 0);
    addv(0, 1, 0, 0,     0, 0);
    addv(0, 1, 1, 32'h0, 0, 0);
    addv(0, 1, 1, 32'h4, 0, 0);
    addv(0, 1, 1, 32'h8, 1, 32'h0);
    addv(0, 1, 1, 32'hC, 1, 32'h4);
    addv(0, 1, 1, 32'h10, 1, 32'h8);
    // Backpressure from reset: FIFO fills, issue stops, head stays at 0.
    addv(1, 0, 0, 0,     0, 0);
    addv(0, 0, 0, 0,     0, 0);
    addv(0, 0, 1, 32'h0, 0, 0);
    addv(0, 0, 1, 32'h4, 0, 0);
    addv(0, 0, 1, 32'h8, 1, 32'h0);
    addv(0, 0, 1, 32'hC, 1, 32'h0);
    for (int i = 0; i < 6; i++) addv(0, 0, 0, 0, 1, 32'h0);
    // Release.
    addv(0, 1, 0, 0,      1, 32'h0);
    addv(0, 1, 1, 32'h10, 1, 32'h4);
    addv(0, 1, 1, 32'h14, 1, 32'h8);

    lat_min = 1; lat_max = 1;
    foreach (vt[i]) begin
      step(vt[i].r, vt[i].rd, vt[i].rpc, vt[i].g, vt[i].dr);
      chk("tbl_req", 32'(s_req), 32'(vt[i].e_req));
      if (vt[i].e_req) chk("tbl_addr", s_addr, vt[i].e_addr);
      chk("tbl_dv", 32'(s_dv), 32'(vt[i].e_dv));
      if (vt[i].e_dv) chk("tbl_pc", s_pc, vt[i].e_pc);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect with two requests in flight.
    lat_min = 4; lat_max = 4;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (pend.size() == 2 && pend[0].due > cyc) found = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    step(1'b0, 1'b1, 32'h103, 1'b1, 1'b1);
    wait_req("redir_addr", 32'h100, 20);
    wait_dv("redir_dec_pc", 32'h100, 30);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect coinciding with a response, then a second redirect next cycle.
    lat_min = 2; lat_max = 2;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc) found = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h80, 1'b1, 1'b1);
    wait_dv("b2b_redir_pc", 32'h80, 30);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // PC wrap-around at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b1);
    wait_dv("wrap_pc", 32'hFFFF_FFF8, 30);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_passed_zero", 32'(exp_dec < 32'h100), 32'd1);

    // Reset mid-stream with the FIFO partly filled.
    lat_min = 1; lat_max = 1;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("rst_mid_dv", 32'(s_dv), 32'd0);
    chk("rst_mid_req", 32'(s_req), 32'd0);
    wait_req("rst_mid_addr", RPC, 5);

    // Randomized traffic.
    lat_min = 1; lat_max = 5;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    ndec = 0;
    for (int i = 0; i < 10000; i++) begin
      step(($urandom % 1000) == 0, ($urandom % 64) == 0, $urandom,
           ($urandom % 4) != 0, ($urandom % 3) != 0);
    end
    chk("rand_progress", 32'(ndec > 1000), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
